// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Shared definitions for the fully-connected tile sequencer and
//               the BRAM data mover. Holds the default datapath widths and the
//               3-bit sequencer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

  // Default widths shared with the data mover
  localparam int CNT_BIT  = 31;
  localparam int AWIDTH   = 12;
  localparam int TILE_BIT = 8;

  // Sequencer state encoding
  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_WAIT = 3'd1;
  localparam state_t S_RUN  = 3'd2;
  localparam state_t S_BUSY = 3'd3;
  localparam state_t S_WB0  = 3'd4;
  localparam state_t S_WB1  = 3'd5;
  localparam state_t S_NEXT = 3'd6;
  localparam state_t S_DONE = 3'd7;

endpackage
`default_nettype wire

// File: rtl/fc_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fc_tile_sequencer
// Description : Runs the FC data mover once per tile for a programmed number
//               of tiles. For each tile it waits for the mover to be idle,
//               pulses run, waits for done, captures the two core results and
//               writes them to the result BRAM at 2*tile and 2*tile+1.
// Ports       : clk, reset_n          - clock, async active-low reset
//               i_start/i_num_tile/i_num_cnt - job request (sampled in idle)
//               o_idle/o_busy/o_done/o_err   - job status
//               o_tile_idx             - current tile
//               o_mv_run/o_mv_num_cnt  - mover control
//               i_mv_idle/i_mv_done    - mover status
//               i_result_0/i_result_1  - core results, valid with i_mv_done
//               addr_r/ce_r/we_r/d_r   - result BRAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module fc_tile_sequencer #(
  parameter int CNT_BIT  = fc_pkg::CNT_BIT,
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = fc_pkg::AWIDTH,
  parameter int TILE_BIT = fc_pkg::TILE_BIT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [TILE_BIT-1:0] i_num_tile,
  input  logic [CNT_BIT-1:0]  i_num_cnt,
  output logic                o_idle,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [TILE_BIT-1:0] o_tile_idx,
  output logic                o_mv_run,
  output logic [CNT_BIT-1:0]  o_mv_num_cnt,
  input  logic                i_mv_idle,
  input  logic                i_mv_done,
  input  logic [DWIDTH-1:0]   i_result_0,
  input  logic [DWIDTH-1:0]   i_result_1,
  output logic [AWIDTH-1:0]   addr_r,
  output logic                ce_r,
  output logic                we_r,
  output logic [DWIDTH-1:0]   d_r
);

  import fc_pkg::*;

  state_t              state_q, state_d;
  logic [TILE_BIT-1:0] num_tile_q;
  logic [TILE_BIT-1:0] tile_idx_q;
  logic [CNT_BIT-1:0]  num_cnt_q;
  logic                err_q;
  logic [DWIDTH-1:0]   r0_q, r1_q;

  logic                w_start_acc;
  logic                w_zero_job;
  logic                w_last_tile;
  logic [AWIDTH-1:0]   w_idx_ext;
  logic [AWIDTH-1:0]   w_addr_even;
  logic [AWIDTH-1:0]   w_addr_odd;

  assign w_start_acc = (state_q == S_IDLE) && i_start;
  assign w_zero_job  = (i_num_tile == '0) || (i_num_cnt == '0);
  assign w_last_tile = (tile_idx_q == (num_tile_q - TILE_BIT'(1)));

  // Two words per tile; the doubling drops the top bit so addresses wrap
  // modulo 2^AWIDTH.
  assign w_idx_ext   = AWIDTH'(tile_idx_q);
  assign w_addr_even = {w_idx_ext[AWIDTH-2:0], 1'b0};
  assign w_addr_odd  = {w_idx_ext[AWIDTH-2:0], 1'b1};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = w_zero_job ? S_DONE : S_WAIT;
        end
      end
      S_WAIT:  if (i_mv_idle) state_d = S_RUN;
      S_RUN:   state_d = S_BUSY;
      S_BUSY:  if (i_mv_done) state_d = S_WB0;
      S_WB0:   state_d = S_WB1;
      S_WB1:   state_d = S_NEXT;
      S_NEXT:  state_d = w_last_tile ? S_DONE : S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (pure decode of the current state)
  // --------------------------------------------------------------------------
  always_comb begin
    o_idle   = 1'b0;
    o_done   = 1'b0;
    o_mv_run = 1'b0;
    ce_r     = 1'b0;
    we_r     = 1'b0;
    addr_r   = '0;
    d_r      = '0;
    o_busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    unique case (state_q)
      S_IDLE: o_idle   = 1'b1;
      S_RUN:  o_mv_run = 1'b1;
      S_WB0: begin
        ce_r   = 1'b1;
        we_r   = 1'b1;
        addr_r = w_addr_even;
        d_r    = r0_q;
      end
      S_WB1: begin
        ce_r   = 1'b1;
        we_r   = 1'b1;
        addr_r = w_addr_odd;
        d_r    = r1_q;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Job registers and result holding registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_tile_q <= '0;
      num_cnt_q  <= '0;
      tile_idx_q <= '0;
      err_q      <= 1'b0;
      r0_q       <= '0;
      r1_q       <= '0;
    end else begin
      if (w_start_acc) begin
        num_tile_q <= i_num_tile;
        num_cnt_q  <= i_num_cnt;
        tile_idx_q <= '0;
        // A zero tile count is a legal empty job; only a zero element count
        // on a non-empty job is flagged.
        err_q      <= (i_num_cnt == '0) && (i_num_tile != '0);
      end
      // Done pulses outside S_BUSY are deliberately ignored.
      if ((state_q == S_BUSY) && i_mv_done) begin
        r0_q <= i_result_0;
        r1_q <= i_result_1;
      end
      if ((state_q == S_NEXT) && !w_last_tile) begin
        tile_idx_q <= tile_idx_q + TILE_BIT'(1);
      end
    end
  end

  assign o_err        = err_q;
  assign o_tile_idx   = tile_idx_q;
  assign o_mv_num_cnt = num_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_tile_sequencer
// Description : Self-checking bench for fc_tile_sequencer. A behavioural mover
//               model answers each run pulse after a programmable latency; a
//               monitor logs runs, BRAM writes and done pulses, which are then
//               compared against expectations from a table, from random jobs
//               with an arithmetic timing model, and from corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_tile_sequencer;

  localparam int CB = 31;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TB = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic [TB-1:0] i_num_tile;
  logic [CB-1:0] i_num_cnt;
  logic          o_idle, o_busy, o_done, o_err;
  logic [TB-1:0] o_tile_idx;
  logic          o_mv_run;
  logic [CB-1:0] o_mv_num_cnt;
  logic          i_mv_idle;
  logic          done_m, done_x;
  logic [DW-1:0] res_m0, res_m1;
  logic [AW-1:0] addr_r;
  logic          ce_r, we_r;
  logic [DW-1:0] d_r;
  wire           mv_done_w = done_m | done_x;

  fc_tile_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_num_tile   (i_num_tile),
    .i_num_cnt    (i_num_cnt),
    .o_idle       (o_idle),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_tile_idx   (o_tile_idx),
    .o_mv_run     (o_mv_run),
    .o_mv_num_cnt (o_mv_num_cnt),
    .i_mv_idle    (i_mv_idle),
    .i_mv_done    (mv_done_w),
    .i_result_0   (res_m0),
    .i_result_1   (res_m1),
    .addr_r       (addr_r),
    .ce_r         (ce_r),
    .we_r         (we_r),
    .d_r          (d_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Mover model configuration and per-tile results
  int            mv_lat = 1;
  logic [DW-1:0] res0_arr [256];
  logic [DW-1:0] res1_arr [256];

  typedef struct {
    logic          ce;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
  } wr_t;

  // Monitor logs
  logic [TB-1:0] run_tile_q [$];
  logic [CB-1:0] run_cnt_q  [$];
  int            run_cyc_q  [$];
  wr_t           wr_q       [$];
  int            done_cyc_q [$];
  logic          done_err_q [$];

  always @(negedge clk) begin
    if (o_mv_run === 1'b1) begin
      run_tile_q.push_back(o_tile_idx);
      run_cnt_q.push_back(o_mv_num_cnt);
      run_cyc_q.push_back(cyc);
    end
    if (ce_r !== 1'b0 || we_r !== 1'b0) begin
      wr_q.push_back('{ce_r, we_r, addr_r, d_r});
    end
    if (o_done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(o_err);
    end
  end

  // Mover model: done arrives mv_lat cycles after the run cycle; results are
  // only meaningful in that cycle, garbage otherwise.
  initial begin
    int k, l;
    done_m = 1'b0;
    res_m0 = 32'hDEAD_0000;
    res_m1 = 32'hBEEF_0000;
    forever begin
      @(negedge clk);
      if (o_mv_run === 1'b1) begin
        k = int'(o_tile_idx);
        l = mv_lat;
        repeat (l) @(posedge clk);
        #1;
        done_m = 1'b1;
        res_m0 = res0_arr[k];
        res_m1 = res1_arr[k];
        @(posedge clk);
        #1;
        done_m = 1'b0;
        res_m0 = 32'hDEAD_0000;
        res_m1 = 32'hBEEF_0000;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  int start_cyc = 0;

  task automatic pulse_start(input logic [TB-1:0] nt, input logic [CB-1:0] cnt);
    @(posedge clk);
    #1;
    i_num_tile = nt;
    i_num_cnt  = cnt;
    i_start    = 1'b1;
    start_cyc  = cyc;
    @(posedge clk);
    #1;
    i_start    = 1'b0;
  endtask

  task automatic wait_done(input int db, output bit got);
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done_cyc_q.size() > db) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL done timeout: got no o_done expected o_done within 5000 cycles");
    end
  endtask

  // Reference timing: start at S, first run at S+2, each tile costs the mover
  // latency, tiles are separated by 5 cycles from done to next run, and the
  // done pulse comes 4 cycles after the last mover done.
  function automatic int model_dlat(input int nt, input logic [CB-1:0] cnt, input int lat);
    if (nt == 0 || cnt == '0) return 1;
    return 2 + nt * lat + (nt - 1) * 5 + 4;
  endfunction

  task automatic check_job(input string name, input int rb, input int wb, input int db,
                           input logic [CB-1:0] cnt, input int exp_runs,
                           input logic exp_err, input int exp_dlat);
    bit got;
    wait_done(db, got);
    if (got) begin
      chk({name, " done latency"}, done_cyc_q[db] - start_cyc, exp_dlat);
      chk({name, " err"}, done_err_q[db], exp_err);
    end
    repeat (3) @(negedge clk);
    chk({name, " done count"}, done_cyc_q.size() - db, 1);
    chk({name, " idle after"}, o_idle, 1'b1);
    chk({name, " run count"}, run_tile_q.size() - rb, exp_runs);
    chk({name, " write count"}, wr_q.size() - wb, 2 * exp_runs);
    if (run_tile_q.size() - rb == exp_runs) begin
      for (int k = 0; k < exp_runs; k++) begin
        chk({name, " run tile_idx"}, run_tile_q[rb + k], k);
        chk({name, " run num_cnt"}, run_cnt_q[rb + k], cnt);
      end
    end
    if (wr_q.size() - wb == 2 * exp_runs) begin
      for (int k = 0; k < exp_runs; k++) begin
        logic [AW-1:0] a0, a1;
        a0 = AW'(2 * k);
        a1 = AW'(2 * k + 1);
        chk({name, " wr0 ce/we"}, {wr_q[wb + 2*k].ce, wr_q[wb + 2*k].we}, 2'b11);
        chk({name, " wr0 addr"}, wr_q[wb + 2*k].addr, a0);
        chk({name, " wr0 data"}, wr_q[wb + 2*k].d, res0_arr[k]);
        chk({name, " wr1 ce/we"}, {wr_q[wb + 2*k + 1].ce, wr_q[wb + 2*k + 1].we}, 2'b11);
        chk({name, " wr1 addr"}, wr_q[wb + 2*k + 1].addr, a1);
        chk({name, " wr1 data"}, wr_q[wb + 2*k + 1].d, res1_arr[k]);
      end
    end
  endtask

  task automatic do_run(input string name, input int nt, input logic [CB-1:0] cnt,
                        input int lat, input int exp_runs, input logic exp_err,
                        input int exp_dlat);
    int rb, wb, db;
    rb = run_tile_q.size();
    wb = wr_q.size();
    db = done_cyc_q.size();
    mv_lat    = lat;
    i_mv_idle = 1'b1;
    pulse_start(TB'(nt), cnt);
    check_job(name, rb, wb, db, cnt, exp_runs, exp_err, exp_dlat);
  endtask

  typedef struct {
    string         name;
    int            nt;
    logic [CB-1:0] cnt;
    int            lat;
    logic [DW-1:0] base0;
    logic [DW-1:0] base1;
    int            exp_runs;
    logic          exp_err;
    int            exp_dlat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #20000000;
    $display("FAIL watchdog: got no end of test expected end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rb, wb, db, rise;
    bit got;

    vecs[0] = '{"basic",     1,   31'd4,          10, 32'h11, 32'h22, 1,   1'b0, 16};
    vecs[1] = '{"multi",     3,   31'd100,        6,  32'hA0, 32'hB0, 3,   1'b0, 34};
    vecs[2] = '{"ntile0",    0,   31'd5,          3,  32'h0,  32'h0,  0,   1'b0, 1};
    vecs[3] = '{"cnt0",      2,   31'd0,          3,  32'h0,  32'h0,  0,   1'b1, 1};
    vecs[4] = '{"both0",     0,   31'd0,          3,  32'h0,  32'h0,  0,   1'b0, 1};
    vecs[5] = '{"maxcnt",    2,   31'h7FFF_FFFF,  1,  32'hFFFF_FFF0, 32'h8000_0000, 2, 1'b0, 13};
    vecs[6] = '{"tiles255",  255, 31'd1,          1,  32'h1000, 32'h2000, 255, 1'b0, 1531};

    reset_n    = 1'b0;
    i_start    = 1'b0;
    i_num_tile = '0;
    i_num_cnt  = '0;
    i_mv_idle  = 1'b1;
    done_x     = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset idle", o_idle, 1'b1);
    chk("reset busy/done/err/run", {o_busy, o_done, o_err, o_mv_run}, 4'b0);
    chk("reset tile_idx/cnt", {o_tile_idx, o_mv_num_cnt}, '0);
    chk("reset bram port", {ce_r, we_r, addr_r, d_r}, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Table-driven jobs
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 256; k++) begin
        res0_arr[k] = vecs[v].base0 + DW'(k);
        res1_arr[k] = vecs[v].base1 + DW'(k);
      end
      do_run(vecs[v].name, vecs[v].nt, vecs[v].cnt, vecs[v].lat,
             vecs[v].exp_runs, vecs[v].exp_err, vecs[v].exp_dlat);
    end

    // Randomized jobs against the arithmetic model
    for (int it = 0; it < 20; it++) begin
      int nt, lat, er;
      logic [CB-1:0] cnt;
      nt  = $urandom_range(0, 5);
      lat = $urandom_range(1, 9);
      cnt = ($urandom_range(0, 7) == 0) ? '0 : CB'($urandom);
      for (int k = 0; k < 8; k++) begin
        res0_arr[k] = $urandom;
        res1_arr[k] = $urandom;
      end
      er = (nt != 0 && cnt != '0) ? nt : 0;
      do_run("random", nt, cnt, lat, er, (cnt == '0) && (nt != 0), model_dlat(nt, cnt, lat));
    end

    // Busy mover: run must wait for i_mv_idle, count held throughout
    for (int k = 0; k < 4; k++) begin
      res0_arr[k] = 32'h5000 + DW'(k);
      res1_arr[k] = 32'h6000 + DW'(k);
    end
    rb = run_tile_q.size();
    wb = wr_q.size();
    db = done_cyc_q.size();
    mv_lat    = 3;
    i_mv_idle = 1'b0;
    pulse_start(8'd1, 31'h0ABC_DEF1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("busymv no run", o_mv_run, 1'b0);
      chk("busymv busy", o_busy, 1'b1);
      chk("busymv cnt stable", o_mv_num_cnt, 31'h0ABC_DEF1);
    end
    @(posedge clk);
    #1;
    i_mv_idle = 1'b1;
    rise = cyc;
    check_job("busymv", rb, wb, db, 31'h0ABC_DEF1, 1, 1'b0, rise + 1 + 3 + 4 - start_cyc);
    if (run_cyc_q.size() > rb) chk("busymv run cycle", run_cyc_q[rb], rise + 1);

    // Spurious done in S_WAIT and start while S_BUSY
    rb = run_tile_q.size();
    wb = wr_q.size();
    db = done_cyc_q.size();
    mv_lat    = 8;
    i_mv_idle = 1'b0;
    pulse_start(8'd2, 31'h1234);
    @(posedge clk);
    #1;
    done_x = 1'b1;
    @(posedge clk);
    #1;
    done_x = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur no write", wr_q.size() - wb, 0);
    chk("spur no run", run_tile_q.size() - rb, 0);
    chk("spur still busy", o_busy, 1'b1);
    @(posedge clk);
    #1;
    i_mv_idle = 1'b1;
    rise = cyc;
    repeat (4) @(posedge clk);
    #1;
    i_num_tile = 8'd9;
    i_num_cnt  = 31'h55;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("busy start cnt held", o_mv_num_cnt, 31'h1234);
    chk("busy start still busy", o_busy, 1'b1);
    check_job("busystart", rb, wb, db, 31'h1234, 2, 1'b0,
              rise + 1 + 8 + 5 + 8 + 4 - start_cyc);

    // Reset in S_WB0
    rb = run_tile_q.size();
    mv_lat    = 4;
    i_mv_idle = 1'b1;
    pulse_start(8'd3, 31'd9);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (we_r === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst reached WB0", got, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst idle", o_idle, 1'b1);
    chk("rst busy/done/err/run", {o_busy, o_done, o_err, o_mv_run}, 4'b0);
    chk("rst tile_idx/cnt", {o_tile_idx, o_mv_num_cnt}, '0);
    chk("rst bram port", {ce_r, we_r, addr_r, d_r}, '0);
    rb = run_tile_q.size();
    wb = wr_q.size();
    db = done_cyc_q.size();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst no writes", wr_q.size() - wb, 0);
    chk("rst no runs", run_tile_q.size() - rb, 0);
    chk("rst no done", done_cyc_q.size() - db, 0);
    chk("rst idle after", o_idle, 1'b1);
    res0_arr[0] = 32'h7777;
    res1_arr[0] = 32'h8888;
    do_run("after reset", 1, 31'd7, 2, 1, 1'b0, model_dlat(1, 31'd7, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_tile_sequencer.md
Name: fc_tile_sequencer

Overview:
- Sequences the fully-connected BRAM data mover over a programmed number of tiles.
- Per tile: waits for the mover to be idle, pulses its run with the element count, waits for its done pulse, captures the two core results, and writes them into a result BRAM.
- Sits between the top-level control register block and the data mover. Replaces software polling of the mover per tile.

Parameters:
- CNT_BIT, 31, width of the per-tile element count (matches the mover's count input)
- DWIDTH, 32, result word width
- AWIDTH, 12, result BRAM address width
- TILE_BIT, 8, width of tile count and tile index

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; sampled only in S_IDLE
- i_num_tile  in  TILE_BIT  number of tiles; captured on accepted start
- i_num_cnt  in  CNT_BIT  elements per tile; captured on accepted start
- o_idle  out  1  high in S_IDLE
- o_busy  out  1  high in any state other than S_IDLE and S_DONE
- o_done  out  1  one-cycle pulse in S_DONE
- o_err  out  1  sticky zero-count flag; cleared on next accepted start
- o_tile_idx  out  TILE_BIT  index of the current tile
- o_mv_run  out  1  run pulse to the mover
- o_mv_num_cnt  out  CNT_BIT  captured count, held stable from start until done
- i_mv_idle  in  1  mover idle status
- i_mv_done  in  1  mover done pulse
- i_result_0, i_result_1  in  DWIDTH each  core results; valid in the i_mv_done cycle
- addr_r  out  AWIDTH  result BRAM address
- ce_r  out  1  result BRAM chip enable
- we_r  out  1  result BRAM write enable
- d_r  out  DWIDTH  result BRAM write data

Behaviour:
- Reset: all state and outputs are 0 and the FSM is in S_IDLE. Reset mid-operation aborts immediately; no further run pulses or writes occur.
- States: S_IDLE, S_WAIT, S_RUN, S_BUSY, S_WB0, S_WB1, S_NEXT, S_DONE.
- S_IDLE:
  - On i_start: capture i_num_tile and i_num_cnt, clear o_tile_idx and o_err.
  - If i_num_tile==0 or i_num_cnt==0, go to S_DONE. o_err is set when i_num_cnt==0 and i_num_tile!=0.
  - Otherwise go to S_WAIT.
- S_WAIT: stay while !i_mv_idle; go to S_RUN when i_mv_idle==1.
- S_RUN: o_mv_run=1 for exactly this one cycle; next state S_BUSY.
- S_BUSY:
  - Wait for i_mv_done.
  - In that cycle, register i_result_0 and i_result_1 into holding regs r0 and r1; next state S_WB0.
  - A done pulse seen in any other state is ignored.
- S_WB0: ce_r=we_r=1, addr_r=2*o_tile_idx, d_r=r0; next state S_WB1.
- S_WB1: ce_r=we_r=1, addr_r=2*o_tile_idx+1, d_r=r1; next state S_NEXT.
- Address arithmetic is done in AWIDTH bits and wraps modulo 2^AWIDTH.
- S_NEXT:
  - If o_tile_idx==num_tile-1, go to S_DONE.
  - Otherwise increment o_tile_idx and go to S_WAIT.
- S_DONE: o_done=1 for one cycle; next state S_IDLE.
- Outside S_WB0/S_WB1: ce_r=we_r=0, addr_r=0, d_r=0.
- i_start is ignored in every state except S_IDLE.
- Timing with mover idle: start accepted at cycle 0, S_WAIT at 1, o_mv_run at 2.
- After i_mv_done at cycle D: writes at D+1 and D+2, S_NEXT at D+3, next o_mv_run at D+5, or o_done at D+4 for the last tile.
- A start in the S_DONE cycle is not accepted; the start accepted on the following S_IDLE cycle is.

Decomposition:
- Shared package (fc_pkg) holds the state encodings (3-bit localparams) and the default widths CNT_BIT, AWIDTH and TILE_BIT, shared with the data mover.
- Single module with no sub-modules. The writeback address/data mux is small enough to stay inline.

Test Plan:
- Basic run: num_tile=1, num_cnt=4; the mover model asserts done 10 cycles after run with results 0x11 and 0x22.
  - Required: exactly one o_mv_run.
  - Required: writes (addr0, 0x11) then (addr1, 0x22).
  - Required: o_done 4 cycles after done, and o_idle afterward.
- Multi-tile: num_tile=3 with results 0xA0+k and 0xB0+k for tile k.
  - Required: 3 run pulses and writes at addresses 0..5 with matching data.
  - Required: o_tile_idx sequence 0,1,2 and a single o_done.
- Busy mover: hold i_mv_idle=0 for 7 cycles after start.
  - Required: o_mv_run is delayed until the cycle after i_mv_idle rises.
  - Required: o_mv_num_cnt stays stable throughout.
- Zero count: num_tile=0 produces o_done 1 cycle after start with o_err=0. num_tile=2 with num_cnt=0 produces o_done and o_err=1, with no run and no writes.
- Start while busy and spurious done:
  - Required: i_start pulsed in S_BUSY changes neither the captured count nor the FSM.
  - Required: i_mv_done injected in S_WAIT causes no write.
- Reset mid-run: deassert reset_n during S_WB0.
  - Required: every output is 0 immediately; no further writes.
  - Required: a new start afterward completes normally.
